// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode definitions and arbiter FSM state encoding.
package alu_arbiter_pkg;

    localparam int unsigned AluOpcodeLen = 4;

    localparam logic [AluOpcodeLen-1:0] AddAlu = 4'h0;
    localparam logic [AluOpcodeLen-1:0] SubAlu = 4'h1;
    localparam logic [AluOpcodeLen-1:0] AndAlu = 4'h2;
    localparam logic [AluOpcodeLen-1:0] OrAlu  = 4'h3;
    localparam logic [AluOpcodeLen-1:0] XorAlu = 4'h4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

    // Only arithmetic opcodes produce a meaningful carry.
    function automatic logic uses_carry(logic [AluOpcodeLen-1:0] opc);
        return (opc == AddAlu) || (opc == SubAlu);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and ALU side signals of the shared-ALU arbiter.
interface alu_arbiter_if import alu_arbiter_pkg::*; #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned OPC_W = AluOpcodeLen
) ();

    logic [NREQ-1:0]       req;
    logic [NREQ*OPC_W-1:0] opcode_in;
    logic [NREQ*8-1:0]     op1_in;
    logic [NREQ*8-1:0]     op2_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [7:0]            result;
    logic                  carry;
    logic                  busy;
    logic                  alu_en;
    logic [OPC_W-1:0]      alu_opcode;
    logic [7:0]            alu_op1;
    logic [7:0]            alu_op2;
    logic [7:0]            alu_out;
    logic                  alu_carry;

    modport master (
        output req, opcode_in, op1_in, op2_in, alu_out, alu_carry,
        input  gnt, done, result, carry, busy, alu_en, alu_opcode, alu_op1, alu_op2
    );

    modport slave (
        input  req, opcode_in, op1_in, op2_in, alu_out, alu_carry,
        output gnt, done, result, carry, busy, alu_en, alu_opcode, alu_op1, alu_op2
    );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1 with wrap.
module rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IdxW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdxW-1:0] idx_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IdxW'((32'(last_i) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU; latches operands, captures result and carry.
module alu_arbiter import alu_arbiter_pkg::*; #(
    parameter int unsigned NREQ = 3
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned OpcW = AluOpcodeLen;

    state_e          state_q, state_d;
    logic [IdxW-1:0] win_q, win_d, last_q, last_d, pick_idx;
    logic [NREQ-1:0] pick_gnt, win_oh;
    logic [OpcW-1:0] opc_q, opc_d, opc_sel;
    logic [7:0]      op1_q, op1_d, op1_sel, op2_q, op2_d, op2_sel;
    logic [7:0]      result_q, result_d;
    logic            carry_q, carry_d;

    rr_pick #(
        .NREQ(NREQ),
        .IdxW(IdxW)
    ) u_pick (
        .req_i (bus.req),
        .last_i(last_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // AND-OR mux over the one-hot pick selects the winner's operands.
    always_comb begin
        opc_sel = '0;
        op1_sel = '0;
        op2_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                opc_sel = opc_sel | bus.opcode_in[i*OpcW +: OpcW];
                op1_sel = op1_sel | bus.op1_in[i*8 +: 8];
                op2_sel = op2_sel | bus.op2_in[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        opc_d    = opc_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        carry_d  = carry_q;
        unique case (state_q)
            StIdle: begin
                if (|pick_gnt) begin
                    win_d   = pick_idx;
                    last_d  = pick_idx;
                    opc_d   = opc_sel;
                    op1_d   = op1_sel;
                    op2_d   = op2_sel;
                    state_d = StExec;
                end
            end
            StExec: begin
                result_d = bus.alu_out;
                carry_d  = uses_carry(opc_q) ? bus.alu_carry : 1'b0;
                state_d  = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            win_q    <= '0;
            last_q   <= IdxW'(NREQ - 1);
            opc_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            opc_q    <= opc_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign win_oh         = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
    assign bus.gnt        = (state_q != StIdle) ? win_oh : '0;
    assign bus.done       = (state_q == StDone) ? win_oh : '0;
    assign bus.busy       = (state_q != StIdle);
    assign bus.alu_en     = (state_q == StExec);
    assign bus.alu_opcode = opc_q;
    assign bus.alu_op1    = op1_q;
    assign bus.alu_op2    = op2_q;
    assign bus.result     = result_q;
    assign bus.carry      = carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned N = 3;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] res;
        logic       c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [8:0] alu_s;

    alu_arbiter_if #(.NREQ(N)) bus ();

    alu_arbiter #(.NREQ(N)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU; non-arithmetic ops drive carry high so the arbiter must clear it.
    always_comb begin
        alu_s         = '0;
        bus.alu_out   = bus.alu_op1;
        bus.alu_carry = 1'b1;
        case (bus.alu_opcode)
            AddAlu: begin
                alu_s         = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
                bus.alu_out   = alu_s[7:0];
                bus.alu_carry = alu_s[8];
            end
            SubAlu: begin
                alu_s         = {1'b0, bus.alu_op1} - {1'b0, bus.alu_op2};
                bus.alu_out   = alu_s[7:0];
                bus.alu_carry = alu_s[8];
            end
            AndAlu:  bus.alu_out = bus.alu_op1 & bus.alu_op2;
            OrAlu:   bus.alu_out = bus.alu_op1 | bus.alu_op2;
            XorAlu:  bus.alu_out = bus.alu_op1 ^ bus.alu_op2;
            default: bus.alu_out = bus.alu_op1;
        endcase
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("done_port", 32'(bus.done), 32'd1 << mon_e.idx);
                check("gnt_eq_done", 32'(bus.gnt), 32'(bus.done));
                check("result", 32'(bus.result), 32'(mon_e.res));
                check("carry", 32'(bus.carry), 32'(mon_e.c));
            end
        end
    end

    task automatic push(int p, logic [7:0] r, logic c);
        exp_t e;
        e.idx = 2'(p);
        e.res = r;
        e.c   = c;
        sb.push_back(e);
    endtask

    task automatic drive_port(int p, logic [AluOpcodeLen-1:0] opc, logic [7:0] a, logic [7:0] b);
        bus.opcode_in[p*AluOpcodeLen +: AluOpcodeLen] = opc;
        bus.op1_in[p*8 +: 8] = a;
        bus.op2_in[p*8 +: 8] = b;
    endtask

    task automatic set_req(int p, logic v);
        if (v) bus.req = bus.req | (3'(1) << p);
        else   bus.req = bus.req & ~(3'(1) << p);
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.done !== '0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none expected=done within 20 cycles");
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_result"}, 32'(bus.result), 32'd0);
        check({tag, "_carry"}, 32'(bus.carry), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_alu_en"}, 32'(bus.alu_en), 32'd0);
        check({tag, "_alu_opcode"}, 32'(bus.alu_opcode), 32'd0);
        check({tag, "_alu_op1"}, 32'(bus.alu_op1), 32'd0);
        check({tag, "_alu_op2"}, 32'(bus.alu_op2), 32'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One isolated operation; optionally scrambles the operands while in EXEC.
    task automatic single_op(int p, logic [AluOpcodeLen-1:0] opc, logic [7:0] a, logic [7:0] b,
                             logic [7:0] r, logic c, bit scramble);
        int c0, at;
        push(p, r, c);
        @(posedge clk);
        #1;
        drive_port(p, opc, a, b);
        set_req(p, 1'b1);
        c0 = cyc;
        @(negedge clk);
        @(negedge clk);
        check("exec_alu_en", 32'(bus.alu_en), 32'd1);
        check("exec_gnt", 32'(bus.gnt), 32'd1 << p);
        check("exec_alu_op1", 32'(bus.alu_op1), 32'(a));
        if (scramble) drive_port(p, opc, 8'hFF, 8'hFF);
        wait_done(at);
        check("latency", 32'(at - c0), 32'd2);
        set_req(p, 1'b0);
    endtask

    initial begin
        int at, prev;
        reset         = 1'b1;
        bus.req       = '0;
        bus.opcode_in = '0;
        bus.op1_in    = '0;
        bus.op2_in    = '0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        reset = 1'b0;

        single_op(0, AddAlu, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        single_op(1, SubAlu, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);
        single_op(1, AndAlu, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_result", 32'(bus.result), 32'h0F);
        check("hold_carry", 32'(bus.carry), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_alu_en", 32'(bus.alu_en), 32'd0);

        // All three requesting continuously.
        do_reset();
        drive_port(0, AddAlu, 8'h01, 8'h02);
        drive_port(1, AddAlu, 8'h80, 8'h80);
        drive_port(2, OrAlu, 8'h0A, 8'h50);
        push(0, 8'h03, 1'b0);
        push(1, 8'h00, 1'b1);
        push(2, 8'h5A, 1'b0);
        push(0, 8'h03, 1'b0);
        @(posedge clk);
        #1 bus.req = 3'b111;
        wait_done(prev);
        for (int k = 1; k < 4; k++) begin
            wait_done(at);
            check("rr3_spacing", 32'(at - prev), 32'd3);
            prev = at;
        end
        bus.req = '0;

        // Requesters 0 and 2 alternate.
        do_reset();
        drive_port(0, SubAlu, 8'h10, 8'h20);
        drive_port(2, XorAlu, 8'hFF, 8'h0F);
        push(0, 8'hF0, 1'b1);
        push(2, 8'hF0, 1'b0);
        push(0, 8'hF0, 1'b1);
        push(2, 8'hF0, 1'b0);
        @(posedge clk);
        #1 bus.req = 3'b101;
        for (int k = 0; k < 4; k++) wait_done(at);
        bus.req = '0;

        single_op(2, AddAlu, 8'h11, 8'h22, 8'h33, 1'b0, 1'b1);

        // Reset during EXEC aborts the operation.
        @(posedge clk);
        #1 drive_port(0, AddAlu, 8'h01, 8'h02);
        set_req(0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("abort_exec_alu_en", 32'(bus.alu_en), 32'd1);
        reset = 1'b1;
        #1 check_all_zero("abort");
        bus.req = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        drive_port(0, AddAlu, 8'h30, 8'h40);
        drive_port(1, SubAlu, 8'h10, 8'h01);
        push(0, 8'h70, 1'b0);
        push(1, 8'h0F, 1'b0);
        bus.req = 3'b011;
        wait_done(prev);
        set_req(0, 1'b0);
        wait_done(at);
        check("post_reset_spacing", 32'(at - prev), 32'd3);
        bus.req = '0;

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
